// File: rtl/mul_scheduler_if.sv
// mul_scheduler_if: handshake between the scheduler and the shared iterative multiplier.
// master = scheduler (start level, operands, sign mode); slave = multiplier (done, product).
interface mul_scheduler_if #(
  parameter int unsigned WIDTH = 32
);
  logic               mul_go;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_signed;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_result;

  modport master (
    output mul_go, mul_a, mul_b, mul_signed,
    input  mul_done, mul_result
  );

  modport slave (
    input  mul_go, mul_a, mul_b, mul_signed,
    output mul_done, mul_result
  );
endinterface

// File: rtl/mul_scheduler.sv
// mul_scheduler: shares one iterative multiplier between the integer EX path (req0) and the FP multiply
// path (req1). Define MUL_SCHED_REUSE_EN to add a one-entry operand/product reuse cache.
module mul_scheduler #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYC = 40,
  parameter int unsigned CNT_W       = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic               sgn0,
  input  logic               sgn1,
  mul_scheduler_if.master    mulBus,
  output logic               stall0,
  output logic               stall1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sgn;
  } opsT;

  stateT             state, stateNxt;
  logic              owner, ownerNxt;
  logic              lastOwner, lastOwnerNxt;
  opsT               ops, opsNxt, grantOps;
  logic              grant, ownerReq;
  logic [CNT_W-1:0]  cnt, cntNxt;
  logic [PROD_W-1:0] resultNxt;
  logic              timeoutErrNxt;
  logic              mulGo, mulGoNxt;
  logic              busyNxt, done0Nxt, done1Nxt;

`ifdef MUL_SCHED_REUSE_EN
  opsT               cacheOps, cacheOpsNxt;
  logic [PROD_W-1:0] cacheProd, cacheProdNxt;
  logic              cacheValid, cacheValidNxt;
`endif

  // State and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      lastOwner   <= 1'b1;
      ops         <= '0;
      cnt         <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
      mulGo       <= 1'b0;
      busy        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
`ifdef MUL_SCHED_REUSE_EN
      cacheOps    <= '0;
      cacheProd   <= '0;
      cacheValid  <= 1'b0;
`endif
    end else begin
      state       <= stateNxt;
      owner       <= ownerNxt;
      lastOwner   <= lastOwnerNxt;
      ops         <= opsNxt;
      cnt         <= cntNxt;
      result      <= resultNxt;
      timeout_err <= timeoutErrNxt;
      mulGo       <= mulGoNxt;
      busy        <= busyNxt;
      done0       <= done0Nxt;
      done1       <= done1Nxt;
`ifdef MUL_SCHED_REUSE_EN
      cacheOps    <= cacheOpsNxt;
      cacheProd   <= cacheProdNxt;
      cacheValid  <= cacheValidNxt;
`endif
    end
  end

  // Arbitration, sequencing and next values of every register
  always_comb begin
    stateNxt      = state;
    ownerNxt      = owner;
    lastOwnerNxt  = lastOwner;
    opsNxt        = ops;
    cntNxt        = cnt;
    resultNxt     = result;
    timeoutErrNxt = timeout_err;
    mulGoNxt      = 1'b0;
    busyNxt       = 1'b0;
    done0Nxt      = 1'b0;
    done1Nxt      = 1'b0;
    grant         = 1'b0;
    grantOps      = '0;
    ownerReq      = 1'b0;
`ifdef MUL_SCHED_REUSE_EN
    cacheOpsNxt   = cacheOps;
    cacheProdNxt  = cacheProd;
    cacheValidNxt = cacheValid;
`endif

    // Round robin only matters under contention; a lone requester always wins
    if (req0 && req1) begin
      grant = ~lastOwner;
    end else begin
      grant = req1;
    end
    grantOps.a   = grant ? a1 : a0;
    grantOps.b   = grant ? b1 : b0;
    grantOps.sgn = grant ? sgn1 : sgn0;
    ownerReq     = owner ? req1 : req0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          ownerNxt = grant;
          if (req0 && req1) begin
            lastOwnerNxt = grant;
          end
`ifdef MUL_SCHED_REUSE_EN
          if (cacheValid && (cacheOps == grantOps)) begin
            resultNxt = cacheProd;
            stateNxt  = DONE;
          end else begin
            opsNxt   = grantOps;
            cntNxt   = '0;
            stateNxt = BUSY;
          end
`else
          opsNxt   = grantOps;
          cntNxt   = '0;
          stateNxt = BUSY;
`endif
        end
      end

      BUSY: begin
        // Flush from the owner beats both mul_done and the timeout
        if (!ownerReq) begin
          stateNxt = IDLE;
`ifdef MUL_SCHED_REUSE_EN
          cacheValidNxt = 1'b0;
`endif
        end else if (mulBus.mul_done) begin
          resultNxt = mulBus.mul_result;
          stateNxt  = DONE;
`ifdef MUL_SCHED_REUSE_EN
          cacheOpsNxt   = ops;
          cacheProdNxt  = mulBus.mul_result;
          cacheValidNxt = 1'b1;
`endif
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          resultNxt     = '0;
          timeoutErrNxt = 1'b1;
          stateNxt      = DONE;
`ifdef MUL_SCHED_REUSE_EN
          cacheValidNxt = 1'b0;
`endif
        end else begin
          cntNxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        stateNxt = IDLE;
      end

      default: begin
        stateNxt = IDLE;
      end
    endcase

    mulGoNxt = (stateNxt == BUSY);
    busyNxt  = (stateNxt != IDLE);
    done0Nxt = (stateNxt == DONE) && !ownerNxt;
    done1Nxt = (stateNxt == DONE) && ownerNxt;
  end

  assign mulBus.mul_go     = mulGo;
  assign mulBus.mul_a      = ops.a;
  assign mulBus.mul_b      = ops.b;
  assign mulBus.mul_signed = ops.sgn;

  // Each requester is released only in its own DONE cycle
  assign stall0 = req0 & ~((state == DONE) && !owner);
  assign stall1 = req1 & ~((state == DONE) && owner);

endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: directed test of mul_scheduler; the bench plays the multiplier and drives
// mul_done/mul_result by hand. Covers the MUL_SCHED_REUSE_EN build when that macro is defined.
module tb_mul_scheduler;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic        sgn0, sgn1;
  logic        stall0, stall1, done0, done1;
  logic [63:0] result;
  logic        busy, timeout_err;

  int nChecks = 0;
  int nFails  = 0;
  int goCnt;
  logic stallLow;

  mul_scheduler_if #(.WIDTH(32)) mulBus ();

  mul_scheduler #(.WIDTH(32), .TIMEOUT_CYC(40), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .a0          (a0),
    .b0          (b0),
    .a1          (a1),
    .b1          (b1),
    .sgn0        (sgn0),
    .sgn1        (sgn1),
    .mulBus      (mulBus.master),
    .stall0      (stall0),
    .stall1      (stall1),
    .done0       (done0),
    .done1       (done1),
    .result      (result),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    sgn0 = 1'b0; sgn1 = 1'b0;
    mulBus.mul_done   = 1'b0;
    mulBus.mul_result = '0;
    step();
    step();

    // Reset values
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_go",      64'(mulBus.mul_go), 64'd0);
    check("rst_done0",   64'(done0), 64'd0);
    check("rst_done1",   64'(done1), 64'd0);
    check("rst_result",  result, 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    step();

    // 1: 7*6 unsigned, multiplier answers in BUSY cycle 32
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd6; sgn0 = 1'b0;
    #1;
    check("t1_stall0_idle", 64'(stall0), 64'd1);
    goCnt = 0;
    stallLow = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (mulBus.mul_go) goCnt++;
      if (!stall0) stallLow = 1'b1;
      if (k == 32) begin
        mulBus.mul_done   = 1'b1;
        mulBus.mul_result = 64'd42;
      end
    end
    check("t1_mul_a",   64'(mulBus.mul_a), 64'd7);
    check("t1_mul_b",   64'(mulBus.mul_b), 64'd6);
    check("t1_mul_sgn", 64'(mulBus.mul_signed), 64'd0);
    check("t1_busy",    64'(busy), 64'd1);
    step();
    mulBus.mul_done = 1'b0;
    check("t1_done0",     64'(done0), 64'd1);
    check("t1_done1",     64'(done1), 64'd0);
    check("t1_result",    result, 64'd42);
    check("t1_stall0",    64'(stall0), 64'd0);
    check("t1_go_done",   64'(mulBus.mul_go), 64'd0);
    check("t1_go_cycles", 64'(goCnt), 64'd32);
    check("t1_stall_low", 64'(stallLow), 64'd0);
    req0 = 1'b0;
    step();
    check("t1_done0_off", 64'(done0), 64'd0);
    check("t1_idle",      64'(busy), 64'd0);

    // 5: repeat the same operands, then the same operands signed
    req0 = 1'b1;
    step();
`ifdef MUL_SCHED_REUSE_EN
    check("t5_hit_done0",  64'(done0), 64'd1);
    check("t5_hit_go",     64'(mulBus.mul_go), 64'd0);
    check("t5_hit_result", result, 64'd42);
    req0 = 1'b0;
    step();
    check("t5_hit_go2",    64'(mulBus.mul_go), 64'd0);
`else
    check("t5_go",    64'(mulBus.mul_go), 64'd1);
    check("t5_done0", 64'(done0), 64'd0);
    mulBus.mul_done   = 1'b1;
    mulBus.mul_result = 64'd42;
    step();
    mulBus.mul_done = 1'b0;
    check("t5_done0_b", 64'(done0), 64'd1);
    req0 = 1'b0;
    step();
`endif
    sgn0 = 1'b1;
    req0 = 1'b1;
    step();
    check("t5_sgn_go",    64'(mulBus.mul_go), 64'd1);
    check("t5_sgn_done0", 64'(done0), 64'd0);
    check("t5_sgn_mode",  64'(mulBus.mul_signed), 64'd1);
    mulBus.mul_done   = 1'b1;
    mulBus.mul_result = 64'd42;
    step();
    mulBus.mul_done = 1'b0;
    check("t5_sgn_done", 64'(done0), 64'd1);
    req0 = 1'b0;
    sgn0 = 1'b0;
    step();

    // 2: simultaneous requests after reset, then round robin
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    a0 = 32'd3; b0 = 32'd5; a1 = 32'd2; b1 = 32'd9;
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("t2_grant0_a", 64'(mulBus.mul_a), 64'd3);
    check("t2_stall1_a", 64'(stall1), 64'd1);
    mulBus.mul_done   = 1'b1;
    mulBus.mul_result = 64'd15;
    step();
    mulBus.mul_done = 1'b0;
    check("t2_done0",    64'(done0), 64'd1);
    check("t2_done1_no", 64'(done1), 64'd0);
    check("t2_stall0",   64'(stall0), 64'd0);
    check("t2_stall1_b", 64'(stall1), 64'd1);
    check("t2_result0",  result, 64'd15);
    req0 = 1'b0;
    step();
    check("t2_stall1_c", 64'(stall1), 64'd1);
    check("t2_idle",     64'(busy), 64'd0);
    step();
    check("t2_grant1_a", 64'(mulBus.mul_a), 64'd2);
    check("t2_go1",      64'(mulBus.mul_go), 64'd1);
    mulBus.mul_done   = 1'b1;
    mulBus.mul_result = 64'd18;
    step();
    mulBus.mul_done = 1'b0;
    check("t2_done1",    64'(done1), 64'd1);
    check("t2_done0_no", 64'(done0), 64'd0);
    check("t2_stall1_d", 64'(stall1), 64'd0);
    check("t2_result1",  result, 64'd18);
    req1 = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("t2_rr_a",      64'(mulBus.mul_a), 64'd2);
    check("t2_rr_stall0", 64'(stall0), 64'd1);
    mulBus.mul_done   = 1'b1;
    mulBus.mul_result = 64'd18;
    step();
    mulBus.mul_done = 1'b0;
    check("t2_rr_done1", 64'(done1), 64'd1);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // 3: abort at BUSY cycle 10, with a coincident mul_done that must lose
    req0 = 1'b1; a0 = 32'd11; b0 = 32'd13;
    for (int k = 1; k <= 10; k++) step();
    check("t3_go_busy", 64'(mulBus.mul_go), 64'd1);
    req0 = 1'b0;
    mulBus.mul_done   = 1'b1;
    mulBus.mul_result = 64'd143;
    step();
    check("t3_busy",   64'(busy), 64'd0);
    check("t3_go",     64'(mulBus.mul_go), 64'd0);
    check("t3_done0",  64'(done0), 64'd0);
    check("t3_result", result, 64'd18);
    step();
    mulBus.mul_done = 1'b0;
    check("t3_idle_done0",  64'(done0), 64'd0);
    check("t3_idle_result", result, 64'd18);

    // 4: no mul_done -> forced completion after 40 BUSY cycles
    req0 = 1'b1; a0 = 32'd4; b0 = 32'd4;
    step();
    repeat (39) step();
    check("t4_go_c40",    64'(mulBus.mul_go), 64'd1);
    check("t4_to_c40",    64'(timeout_err), 64'd0);
    check("t4_done0_c40", 64'(done0), 64'd0);
    step();
    check("t4_done0",   64'(done0), 64'd1);
    check("t4_result",  result, 64'd0);
    check("t4_timeout", 64'(timeout_err), 64'd1);
    req0 = 1'b0;
    step();
    check("t4_sticky",  64'(timeout_err), 64'd1);
    check("t4_idle",    64'(busy), 64'd0);

    // 6: asynchronous reset at BUSY cycle 5
    req0 = 1'b1; a0 = 32'd9; b0 = 32'd9;
    step();
    repeat (4) step();
    check("t6_go_pre", 64'(mulBus.mul_go), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_busy",    64'(busy), 64'd0);
    check("t6_go",      64'(mulBus.mul_go), 64'd0);
    check("t6_done0",   64'(done0), 64'd0);
    check("t6_timeout", 64'(timeout_err), 64'd0);
    check("t6_mul_a",   64'(mulBus.mul_a), 64'd0);
    check("t6_stall0",  64'(stall0), 64'd1);
    reset = 1'b0;
    req0  = 1'b0;
    step();
    check("t6_after_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
